// File: rtl/morra_pkg.sv
// morra_pkg: shared types for the rock-paper-scissors game and its tournament
// tally stage.
//   esito_t        - result encoding used by both the FSMD and the tally stage
//   torneo_state_t - tally-stage control states
package morra_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,   // invalid round / play in progress / tournament ongoing
        G1   = 2'b01,   // player 1
        G2   = 2'b10,   // player 2
        PARI = 2'b11    // draw
    } esito_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PLAY   = 2'b01,
        SETTLE = 2'b10,
        DONE   = 2'b11
    } torneo_state_t;

    // Width of the per-play round counter (saturates at 31).
    localparam int MANCHE_W = 5;

endpackage

// File: rtl/morra_torneo_if.sv
// morra_torneo_if: bundles the tally stage's control inputs and its score
// outputs.
//   slave  - the tally stage: receives clear/game_reset/manche/partita,
//            drives the counters, play_done, torneo and torneo_done
//   master - the environment driving the results and reading the scores
interface morra_torneo_if #(
    parameter int CW = 4
);
    import morra_pkg::*;

    logic                clear;
    logic                game_reset;
    esito_t              manche;
    esito_t              partita;
    logic [CW-1:0]       wins_g1;
    logic [CW-1:0]       wins_g2;
    logic [CW-1:0]       draws;
    logic [CW-1:0]       plays;
    logic [MANCHE_W-1:0] manche_cnt;
    logic                play_done;
    esito_t              torneo;
    logic                torneo_done;

    modport slave (
        input  clear, game_reset, manche, partita,
        output wins_g1, wins_g2, draws, plays, manche_cnt,
               play_done, torneo, torneo_done
    );

    modport master (
        output clear, game_reset, manche, partita,
        input  wins_g1, wins_g2, draws, plays, manche_cnt,
               play_done, torneo, torneo_done
    );
endinterface

// File: rtl/morra_sat_cnt.sv
// morra_sat_cnt: up-counter that sticks at its all-ones value.
//   clk, reset_n - clock, asynchronous active-low reset
//   clr          - synchronous clear, overrides inc
//   inc          - add one this cycle (ignored once saturated)
//   cnt          - current count
module morra_sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/morra_torneo.sv
// morra_torneo: tournament tally stage sitting beside the game FSMD.
// Counts valid rounds in the current play, tallies each play result exactly
// once, and closes the tournament when a player reaches WIN_TARGET wins or
// after MAX_PLAYS plays.
//   clk, reset_n - clock, asynchronous active-low reset
//   bus (slave)  - clear, game_reset, manche, partita in;
//                  wins_g1, wins_g2, draws, plays, manche_cnt, play_done,
//                  torneo, torneo_done out
module morra_torneo
    import morra_pkg::*;
#(
    parameter int WIN_TARGET = 3,
    parameter int MAX_PLAYS  = 7,
    parameter int CW         = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    morra_torneo_if.slave  bus
);
    localparam logic [CW-1:0] WIN_T = CW'(WIN_TARGET);
    localparam logic [CW-1:0] MAX_P = CW'(MAX_PLAYS);

    torneo_state_t state_q, state_d;
    esito_t        torneo_q, torneo_d;
    logic          play_done_q, play_done_d;

    logic [CW-1:0]       wins_g1, wins_g2, draws, plays;
    logic [MANCHE_W-1:0] manche_cnt;

    // Live PLAY cycle: not overridden by clear or a new-play reset.
    logic play_live;
    logic tally;
    logic inc_g1, inc_g2, inc_pari;
    logic mc_clr;
    logic [CW-1:0] g1_post, g2_post, plays_post;

    always_comb begin
        play_live = (state_q == PLAY) && !bus.clear && !bus.game_reset;
        tally     = play_live && (bus.partita != NONE);
        inc_g1    = tally && (bus.partita == G1);
        inc_g2    = tally && (bus.partita == G2);
        inc_pari  = tally && (bus.partita == PARI);
        // A new play (or abort) restarts the round count; DONE and IDLE ignore it.
        mc_clr    = bus.clear ||
                    (bus.game_reset && ((state_q == PLAY) || (state_q == SETTLE)));
        // The decision looks at the scores including this cycle's tally.
        // Overflow cannot happen here: plays never exceed MAX_PLAYS.
        g1_post    = wins_g1 + CW'(inc_g1);
        g2_post    = wins_g2 + CW'(inc_g2);
        plays_post = plays + CW'(tally);
    end

    always_comb begin
        state_d     = state_q;
        torneo_d    = torneo_q;
        play_done_d = tally;
        if (bus.clear) begin
            state_d  = IDLE;
            torneo_d = NONE;
        end else begin
            unique case (state_q)
                IDLE:   if (bus.game_reset) state_d = PLAY;
                PLAY: begin
                    if (tally) begin
                        if (g1_post == WIN_T) begin
                            torneo_d = G1;
                            state_d  = DONE;
                        end else if (g2_post == WIN_T) begin
                            torneo_d = G2;
                            state_d  = DONE;
                        end else if (plays_post == MAX_P) begin
                            if (g1_post > g2_post)      torneo_d = G1;
                            else if (g1_post < g2_post) torneo_d = G2;
                            else                        torneo_d = PARI;
                            state_d = DONE;
                        end else begin
                            state_d = SETTLE;
                        end
                    end
                end
                SETTLE: if (bus.game_reset) state_d = PLAY;
                DONE:   state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            torneo_q    <= NONE;
            play_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            torneo_q    <= torneo_d;
            play_done_q <= play_done_d;
        end
    end

    morra_sat_cnt #(.W(CW)) u_wins_g1 (
        .clk(clk), .reset_n(reset_n), .clr(bus.clear), .inc(inc_g1), .cnt(wins_g1)
    );
    morra_sat_cnt #(.W(CW)) u_wins_g2 (
        .clk(clk), .reset_n(reset_n), .clr(bus.clear), .inc(inc_g2), .cnt(wins_g2)
    );
    morra_sat_cnt #(.W(CW)) u_draws (
        .clk(clk), .reset_n(reset_n), .clr(bus.clear), .inc(inc_pari), .cnt(draws)
    );
    morra_sat_cnt #(.W(CW)) u_plays (
        .clk(clk), .reset_n(reset_n), .clr(bus.clear), .inc(tally), .cnt(plays)
    );
    morra_sat_cnt #(.W(MANCHE_W)) u_manche_cnt (
        .clk(clk), .reset_n(reset_n), .clr(mc_clr),
        .inc(play_live && (bus.manche != NONE)), .cnt(manche_cnt)
    );

    assign bus.wins_g1     = wins_g1;
    assign bus.wins_g2     = wins_g2;
    assign bus.draws       = draws;
    assign bus.plays       = plays;
    assign bus.manche_cnt  = manche_cnt;
    assign bus.play_done   = play_done_q;
    assign bus.torneo      = torneo_q;
    assign bus.torneo_done = (state_q == DONE);
endmodule
